// File: rtl/hazard_field_pkg.sv
// Shared game constants and helpers for the hazard field: coordinate width,
// default sprite/hitbox sizes, animation tick divider and packed-field access.
package hazard_field_pkg;

    localparam int COORD_W        = 10;
    localparam int HAZ_SIZE_DEF   = 12;
    localparam int CHAR_SIZE_DEF  = 12;
    localparam int TICK_DIV_DEF   = 833333;
    localparam int MAX_FIELDS     = 32;

    typedef enum logic {
        DIR_DOWN = 1'b0,
        DIR_UP   = 1'b1
    } dir_e;

    // Callers zero-pad their packed per-hazard vector up to MAX_FIELDS entries.
    function automatic logic [COORD_W-1:0] field10(
        input logic [MAX_FIELDS*COORD_W-1:0] vec,
        input int unsigned                   idx
    );
        logic [MAX_FIELDS*COORD_W-1:0] shifted;
        shifted = vec >> (idx * COORD_W);
        return shifted[COORD_W-1:0];
    endfunction

endpackage

// File: rtl/hazard_field_patrol.sv
// One hazard's vertical patrol: bouncing offset in 0..AMPL, direction and
// alive flag. restart overrides both the animation tick and a kill.
module hazard_patrol
    import hazard_field_pkg::*;
#(
    parameter int AMPL = 24,
    parameter int STEP = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               tick_i,
    input  logic               restart_i,
    input  logic               kill_i,
    output logic [COORD_W-1:0] offset_o,
    output logic               en_o
);

    logic [COORD_W-1:0] off_q, off_d;
    dir_e               dir_q, dir_d;
    logic               en_q,  en_d;
    logic [COORD_W:0]   off_up;

    assign off_up = {1'b0, off_q} + (COORD_W+1)'(STEP);

    always_comb begin
        off_d = off_q;
        dir_d = dir_q;
        en_d  = en_q;
        if (restart_i) begin
            off_d = '0;
            dir_d = DIR_DOWN;
            en_d  = 1'b1;
        end else begin
            // A disabled hazard freezes where it was hit.
            if (tick_i && en_q) begin
                if (dir_q == DIR_DOWN) begin
                    if (off_up >= (COORD_W+1)'(AMPL)) begin
                        off_d = COORD_W'(AMPL);
                        dir_d = DIR_UP;
                    end else begin
                        off_d = off_up[COORD_W-1:0];
                    end
                end else begin
                    if (off_q <= COORD_W'(STEP)) begin
                        off_d = '0;
                        dir_d = DIR_DOWN;
                    end else begin
                        off_d = off_q - COORD_W'(STEP);
                    end
                end
            end
            if (kill_i) begin
                en_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            off_q <= '0;
            dir_q <= DIR_DOWN;
            en_q  <= 1'b1;
        end else begin
            off_q <= off_d;
            dir_q <= dir_d;
            en_q  <= en_d;
        end
    end

    assign offset_o = off_q;
    assign en_o     = en_q;

endmodule

// File: rtl/hazard_field.sv
// Array of animated poison-star hazards: tick divider, per-hazard patrol,
// world-space collision, lowest-index hit registration and death outputs.
module hazard_field
    import hazard_field_pkg::*;
#(
    parameter int N_HAZ     = 4,
    parameter int HAZ_SIZE  = HAZ_SIZE_DEF,
    parameter int CHAR_SIZE = CHAR_SIZE_DEF,
    parameter int TICK_DIV  = TICK_DIV_DEF,
    parameter int AMPL      = 24,
    parameter int STEP      = 1,
    parameter logic [N_HAZ*COORD_W-1:0] BASE_X = {N_HAZ{10'd180}},
    parameter logic [N_HAZ*COORD_W-1:0] BASE_Y = {N_HAZ{10'd36}},
    localparam int IDX_W = (N_HAZ > 1) ? $clog2(N_HAZ) : 1,
    localparam int CNT_W = $clog2(TICK_DIV)
) (
    input  logic                       sys_clk,
    input  logic                       RST_N,
    input  logic [COORD_W-1:0]         char_X,
    input  logic [COORD_W-1:0]         char_Y,
    input  logic [COORD_W-1:0]         bg_pos,
    input  logic                       restart,
    output logic [N_HAZ*COORD_W-1:0]   haz_x,
    output logic [N_HAZ*COORD_W-1:0]   haz_y,
    output logic [N_HAZ-1:0]           haz_en,
    output logic                       death,
    output logic                       death_latched,
    output logic [IDX_W-1:0]           hit_idx
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tick;

    assign tick  = (cnt_q == CNT_W'(TICK_DIV - 1));
    assign cnt_d = tick ? '0 : cnt_q + CNT_W'(1);

    // The divider keeps running through restart; only RST_N clears it.
    always_ff @(posedge sys_clk or negedge RST_N) begin
        if (!RST_N) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    logic [MAX_FIELDS*COORD_W-1:0] base_x_ext, base_y_ext;
    always_comb begin
        base_x_ext = '0;
        base_y_ext = '0;
        base_x_ext[N_HAZ*COORD_W-1:0] = BASE_X;
        base_y_ext[N_HAZ*COORD_W-1:0] = BASE_Y;
    end

    logic [N_HAZ-1:0] hit, kill;

    for (genvar i = 0; i < N_HAZ; i++) begin : g_haz
        logic [COORD_W-1:0] offset, wx, wy;
        logic [COORD_W:0]   hx, hy, cx, cy;

        hazard_patrol #(
            .AMPL (AMPL),
            .STEP (STEP)
        ) u_patrol (
            .clk       (sys_clk),
            .rst_n     (RST_N),
            .tick_i    (tick),
            .restart_i (restart),
            .kill_i    (kill[i]),
            .offset_o  (offset),
            .en_o      (haz_en[i])
        );

        assign wx = field10(base_x_ext, i);
        assign wy = field10(base_y_ext, i) + offset;
        assign haz_x[i*COORD_W +: COORD_W] = wx - bg_pos;
        assign haz_y[i*COORD_W +: COORD_W] = wy;

        // 11-bit compares so box edges near 1023 never wrap; touching counts.
        assign hx = {1'b0, wx};
        assign hy = {1'b0, wy};
        assign cx = {1'b0, char_X};
        assign cy = {1'b0, char_Y};
        assign hit[i] = haz_en[i]
                      & (cx <= hx + (COORD_W+1)'(HAZ_SIZE))
                      & (hx <= cx + (COORD_W+1)'(CHAR_SIZE))
                      & (cy <= hy + (COORD_W+1)'(HAZ_SIZE))
                      & (hy <= cy + (COORD_W+1)'(CHAR_SIZE));
    end

    // Isolate the lowest set bit: only that hazard is retired this cycle.
    assign kill = hit & (~hit + N_HAZ'(1));

    logic [IDX_W-1:0] sel;
    logic             any_hit;
    always_comb begin
        sel     = '0;
        any_hit = 1'b0;
        for (int i = N_HAZ - 1; i >= 0; i--) begin
            if (hit[i]) begin
                sel     = IDX_W'(i);
                any_hit = 1'b1;
            end
        end
    end

    logic             death_q,   death_d;
    logic             latched_q, latched_d;
    logic [IDX_W-1:0] idx_q,     idx_d;

    always_comb begin
        death_d   = any_hit;
        latched_d = latched_q | any_hit;
        idx_d     = any_hit ? sel : idx_q;
        if (restart) begin
            death_d   = 1'b0;
            latched_d = 1'b0;
            idx_d     = '0;
        end
    end

    always_ff @(posedge sys_clk or negedge RST_N) begin
        if (!RST_N) begin
            death_q   <= 1'b0;
            latched_q <= 1'b0;
            idx_q     <= '0;
        end else begin
            death_q   <= death_d;
            latched_q <= latched_d;
            idx_q     <= idx_d;
        end
    end

    assign death         = death_q;
    assign death_latched = latched_q;
    assign hit_idx       = idx_q;

endmodule

// File: tb/tb_hazard_field.sv
// Directed bench for hazard_field: patrol animation, collision edges,
// multi-hit ordering, restart priority and screen-X wrap.
module tb_hazard_field;

    localparam int N_HAZ = 4;

    logic        sys_clk = 1'b0;
    logic        RST_N   = 1'b0;
    logic [9:0]  char_X  = 10'd0;
    logic [9:0]  char_Y  = 10'd500;
    logic [9:0]  bg_pos  = 10'd0;
    logic        restart = 1'b0;
    logic [39:0] haz_x, haz_y;
    logic [3:0]  haz_en;
    logic        death, death_latched;
    logic [1:0]  hit_idx;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    hazard_field #(
        .N_HAZ    (4),
        .HAZ_SIZE (12),
        .CHAR_SIZE(12),
        .TICK_DIV (4),
        .AMPL     (3),
        .STEP     (2),
        .BASE_X   ({10'd405, 10'd600, 10'd400, 10'd180}),
        .BASE_Y   ({4{10'd36}})
    ) dut (
        .sys_clk      (sys_clk),
        .RST_N        (RST_N),
        .char_X       (char_X),
        .char_Y       (char_Y),
        .bg_pos       (bg_pos),
        .restart      (restart),
        .haz_x        (haz_x),
        .haz_y        (haz_y),
        .haz_en       (haz_en),
        .death        (death),
        .death_latched(death_latched),
        .hit_idx      (hit_idx)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic do_restart();
        char_X  = 10'd0;
        char_Y  = 10'd500;
        restart = 1'b1;
        step();
        restart = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) step();
        chk_cnt++;
        if (death !== 1'b0 || death_latched !== 1'b0 || hit_idx !== 2'd0)
            $display("FAIL reset_flags death=%b latched=%b idx=%0d required 0/0/0", death, death_latched, hit_idx);
        else pass_cnt++;
        chk_cnt++;
        if (haz_en !== 4'b1111) $display("FAIL reset_en got %b required 1111", haz_en);
        else pass_cnt++;
        chk_cnt++;
        if (haz_y !== {4{10'd36}}) $display("FAIL reset_y got %h required all 36", haz_y);
        else pass_cnt++;
    endtask

    task automatic test_patrol();
        int exp_y[5] = '{38, 39, 37, 36, 38};
        RST_N = 1'b1;
        chk_cnt++;
        if (haz_y[9:0] !== 10'd36) $display("FAIL patrol_y0 got %0d required 36", haz_y[9:0]);
        else pass_cnt++;
        for (int k = 0; k < 5; k++) begin
            repeat (4) step();
            chk_cnt++;
            if (haz_y[9:0] !== 10'(exp_y[k]))
                $display("FAIL patrol_y tick%0d got %0d required %0d", k + 1, haz_y[9:0], exp_y[k]);
            else pass_cnt++;
        end
        chk_cnt++;
        if (haz_en !== 4'b1111 || death !== 1'b0)
            $display("FAIL patrol_idle en=%b death=%b required 1111/0", haz_en, death);
        else pass_cnt++;
    endtask

    task automatic test_single_hit();
        do_restart();
        char_X = 10'd180;
        char_Y = 10'd36;
        step();
        chk_cnt++;
        if (death !== 1'b1 || death_latched !== 1'b1 || hit_idx !== 2'd0 || haz_en !== 4'b1110)
            $display("FAIL hit0 death=%b latched=%b idx=%0d en=%b required 1/1/0/1110",
                     death, death_latched, hit_idx, haz_en);
        else pass_cnt++;
        for (int k = 0; k < 3; k++) begin
            step();
            chk_cnt++;
            if (death !== 1'b0 || death_latched !== 1'b1)
                $display("FAIL hit0_hold cyc%0d death=%b latched=%b required 0/1", k, death, death_latched);
            else pass_cnt++;
        end
    endtask

    task automatic test_edges();
        int  ex[4] = '{192, 193, 167, 168};
        int  ey[4] = '{48, 36, 36, 36};
        logic eh[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        for (int k = 0; k < 4; k++) begin
            do_restart();
            char_X = 10'(ex[k]);
            char_Y = 10'(ey[k]);
            step();
            chk_cnt++;
            if (death !== eh[k])
                $display("FAIL edge x=%0d y=%0d death=%b required %b", ex[k], ey[k], death, eh[k]);
            else pass_cnt++;
        end
    endtask

    task automatic test_back_to_back();
        do_restart();
        char_X = 10'd402;
        char_Y = 10'd36;
        step();
        chk_cnt++;
        if (death !== 1'b1 || hit_idx !== 2'd1 || haz_en !== 4'b1101)
            $display("FAIL b2b_first death=%b idx=%0d en=%b required 1/1/1101", death, hit_idx, haz_en);
        else pass_cnt++;
        step();
        chk_cnt++;
        if (death !== 1'b1 || hit_idx !== 2'd3 || haz_en !== 4'b0101)
            $display("FAIL b2b_second death=%b idx=%0d en=%b required 1/3/0101", death, hit_idx, haz_en);
        else pass_cnt++;
        step();
        chk_cnt++;
        if (death !== 1'b0 || haz_en !== 4'b0101 || hit_idx !== 2'd3)
            $display("FAIL b2b_after death=%b en=%b idx=%0d required 0/0101/3", death, haz_en, hit_idx);
        else pass_cnt++;
    endtask

    task automatic test_wrap();
        do_restart();
        bg_pos = 10'd200;
        #1;
        chk_cnt++;
        if (haz_x[9:0] !== 10'd1004) $display("FAIL wrap_x0 got %0d required 1004", haz_x[9:0]);
        else pass_cnt++;
        chk_cnt++;
        if (haz_x[19:10] !== 10'd200) $display("FAIL wrap_x1 got %0d required 200", haz_x[19:10]);
        else pass_cnt++;
        char_X = 10'd182;
        char_Y = 10'd40;
        step();
        chk_cnt++;
        if (death !== 1'b1 || hit_idx !== 2'd0)
            $display("FAIL wrap_hit death=%b idx=%0d required 1/0", death, hit_idx);
        else pass_cnt++;
        bg_pos = 10'd0;
    endtask

    task automatic test_restart_priority();
        // death_latched is still set from the previous scenario here.
        restart = 1'b1;
        char_X  = 10'd180;
        char_Y  = 10'd36;
        step();
        chk_cnt++;
        if (death !== 1'b0 || death_latched !== 1'b0 || haz_en !== 4'b1111)
            $display("FAIL restart_prio death=%b latched=%b en=%b required 0/0/1111",
                     death, death_latched, haz_en);
        else pass_cnt++;
        chk_cnt++;
        if (haz_y !== {4{10'd36}}) $display("FAIL restart_offsets got %h required all 36", haz_y);
        else pass_cnt++;
        restart = 1'b0;
        char_X  = 10'd0;
        char_Y  = 10'd500;
        step();
        chk_cnt++;
        if (death !== 1'b0 || haz_en !== 4'b1111)
            $display("FAIL restart_after death=%b en=%b required 0/1111", death, haz_en);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        @(posedge sys_clk);
        #1;
        test_patrol();
        test_single_hit();
        test_edges();
        test_back_to_back();
        test_wrap();
        test_restart_priority();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
